// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of a single shared SRAM port.
// m2 (data) normally wins; m1 (fetch) gains priority once it has been
// denied AGE_MAX consecutive cycles. One transaction is outstanding at a time.
module mem_port_arbiter #(
    parameter int unsigned AGE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [63:0] m1_addr,
    input  logic [63:0] m1_wdata,
    input  logic [7:0]  m1_wstrb,
    output logic        m1_gnt,
    output logic        m1_rsp_valid,
    output logic [63:0] m1_rdata,

    input  logic        m2_req,
    input  logic        m2_we,
    input  logic [63:0] m2_addr,
    input  logic [63:0] m2_wdata,
    input  logic [7:0]  m2_wstrb,
    output logic        m2_gnt,
    output logic        m2_rsp_valid,
    output logic [63:0] m2_rdata,

    output logic        s_req,
    output logic        s_we,
    output logic [63:0] s_addr,
    output logic [63:0] s_wdata,
    output logic [7:0]  s_wstrb,
    input  logic        s_ack,
    input  logic        s_rsp_valid,
    input  logic [63:0] s_rdata,

    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

    localparam logic [3:0] AGE_LIMIT = 4'(AGE_MAX);

    state_t      state_q, state_d;
    logic [3:0]  age_q;
    logic        owner_q;
    logic        cap_we;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wstrb;

    logic        pick_m1, pick_m2, done;

    // Winner selection in IDLE and completion detection in ISSUE/WAIT_RSP
    always_comb begin
        pick_m1 = (state_q == IDLE) && m1_req && (!m2_req || age_q >= AGE_LIMIT);
        pick_m2 = (state_q == IDLE) && m2_req && !pick_m1;
        done    = ((state_q == ISSUE) && s_ack && s_rsp_valid) ||
                  ((state_q == WAIT_RSP) && s_rsp_valid);
    end

    // Next-state logic; s_rsp_valid without s_ack in ISSUE is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (pick_m1 || pick_m2) state_d = ISSUE;
            ISSUE:    if (s_ack) state_d = s_rsp_valid ? IDLE : WAIT_RSP;
            WAIT_RSP: if (s_rsp_valid) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register, m1 aging counter and transaction capture on grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            age_q     <= '0;
            owner_q   <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
        end else begin
            state_q <= state_d;
            if (pick_m1)
                age_q <= '0;
            else if (m1_req && age_q < AGE_LIMIT)
                age_q <= age_q + 4'd1;
            if (pick_m1 || pick_m2) begin
                owner_q   <= pick_m2;
                cap_we    <= pick_m2 ? m2_we    : m1_we;
                cap_addr  <= pick_m2 ? m2_addr  : m1_addr;
                cap_wdata <= pick_m2 ? m2_wdata : m1_wdata;
                cap_wstrb <= pick_m2 ? m2_wstrb : m1_wstrb;
            end
        end
    end

    // Output decode; everything is held low while rst is asserted
    always_comb begin
        m1_gnt       = 1'b0;
        m2_gnt       = 1'b0;
        m1_rsp_valid = 1'b0;
        m2_rsp_valid = 1'b0;
        m1_rdata     = '0;
        m2_rdata     = '0;
        s_req        = 1'b0;
        s_we         = 1'b0;
        s_addr       = '0;
        s_wdata      = '0;
        s_wstrb      = '0;
        busy         = 1'b0;
        owner        = 1'b0;
        if (!rst) begin
            m1_gnt       = pick_m1;
            m2_gnt       = pick_m2;
            m1_rsp_valid = done && !owner_q;
            m2_rsp_valid = done && owner_q;
            m1_rdata     = m1_rsp_valid ? s_rdata : '0;
            m2_rdata     = m2_rsp_valid ? s_rdata : '0;
            busy         = (state_q != IDLE);
            owner        = owner_q;
            if (state_q == ISSUE) begin
                s_req   = 1'b1;
                s_we    = cap_we;
                s_addr  = cap_addr;
                s_wdata = cap_wdata;
                s_wstrb = cap_wstrb;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run, all compared cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AGE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m1_req, m1_we, m2_req, m2_we;
    logic [63:0] m1_addr, m1_wdata, m2_addr, m2_wdata;
    logic [7:0]  m1_wstrb, m2_wstrb;
    logic        m1_gnt, m1_rsp_valid, m2_gnt, m2_rsp_valid;
    logic [63:0] m1_rdata, m2_rdata;
    logic        s_req, s_we, s_ack, s_rsp_valid;
    logic [63:0] s_addr, s_wdata, s_rdata;
    logic [7:0]  s_wstrb;
    logic        busy, owner;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AGE_MAX(AGE_MAX)) dut (
        .clk(clk), .rst(rst),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
        .m2_req(m2_req), .m2_we(m2_we), .m2_addr(m2_addr), .m2_wdata(m2_wdata),
        .m2_wstrb(m2_wstrb), .m2_gnt(m2_gnt), .m2_rsp_valid(m2_rsp_valid), .m2_rdata(m2_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ack(s_ack), .s_rsp_valid(s_rsp_valid), .s_rdata(s_rdata),
        .busy(busy), .owner(owner)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: phase 0 = no transaction, 1 = waiting for slave accept, 2 = waiting for completion
    int          ph = 0, age = 0, own = 0;
    logic        t_we = 1'b0;
    logic [63:0] t_addr = '0, t_wdata = '0;
    logic [7:0]  t_wstrb = '0;
    int          n_ph, n_age, n_own;
    logic        n_we;
    logic [63:0] n_addr, n_wdata;
    logic [7:0]  n_wstrb;

    logic        e_rsp1, e_rsp2, e_sreq;
    logic [207:0] exp_v, got;

    task automatic idle_inputs();
        rst = 1'b0; s_ack = 1'b0; s_rsp_valid = 1'b0; s_rdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        m2_req = 1'b0; m2_we = 1'b0; m2_addr = '0; m2_wdata = '0; m2_wstrb = '0;
    endtask

    task automatic rand_fields();
        m1_we = 1'($urandom); m1_addr = {$urandom, $urandom}; m1_wdata = {$urandom, $urandom};
        m1_wstrb = 8'($urandom);
        m2_we = 1'($urandom); m2_addr = {$urandom, $urandom}; m2_wdata = {$urandom, $urandom};
        m2_wstrb = 8'($urandom);
        s_rdata = {$urandom, $urandom};
    endtask

    // Expected outputs for the current cycle and the model's next state
    task automatic model_eval();
        logic g1, g2, dn;
        g1 = 1'b0; g2 = 1'b0; dn = 1'b0;
        n_ph = ph; n_age = age; n_own = own;
        n_we = t_we; n_addr = t_addr; n_wdata = t_wdata; n_wstrb = t_wstrb;
        if (rst) begin
            n_ph = 0; n_age = 0; n_own = 0;
            n_we = 1'b0; n_addr = '0; n_wdata = '0; n_wstrb = '0;
        end else begin
            if (ph == 0) begin
                if (m1_req && (age >= int'(AGE_MAX) || !m2_req)) g1 = 1'b1;
                else if (m2_req) g2 = 1'b1;
                if (g1 || g2) begin
                    n_ph = 1; n_own = g2 ? 1 : 0;
                    n_we    = g2 ? m2_we    : m1_we;
                    n_addr  = g2 ? m2_addr  : m1_addr;
                    n_wdata = g2 ? m2_wdata : m1_wdata;
                    n_wstrb = g2 ? m2_wstrb : m1_wstrb;
                end
            end else if (ph == 1) begin
                if (s_ack) begin
                    if (s_rsp_valid) begin dn = 1'b1; n_ph = 0; end
                    else n_ph = 2;
                end
            end else if (s_rsp_valid) begin
                dn = 1'b1; n_ph = 0;
            end
            if (g1) n_age = 0;
            else if (m1_req) n_age = (age + 1 > int'(AGE_MAX)) ? int'(AGE_MAX) : age + 1;
        end
        e_rsp1 = dn && own == 0;
        e_rsp2 = dn && own == 1;
        e_sreq = !rst && ph == 1;
        exp_v = {g1, g2, e_rsp1, e_rsp2, !rst && ph != 0, !rst && own == 1, e_sreq,
                 (e_rsp1 || e_rsp2) ? s_rdata : 64'd0,
                 e_sreq ? {t_we, t_addr, t_wdata, t_wstrb} : 137'd0};
    endtask

    function automatic logic [207:0] observed();
        logic [63:0] rd;
        rd = e_rsp1 ? m1_rdata : (e_rsp2 ? m2_rdata : 64'd0);
        return {m1_gnt, m2_gnt, m1_rsp_valid, m2_rsp_valid, busy, owner, s_req, rd,
                e_sreq ? {s_we, s_addr, s_wdata, s_wstrb} : 137'd0};
    endfunction

    task automatic sample();
        @(negedge clk);
        model_eval();
        got = observed();
    endtask

    task automatic commit();
        @(posedge clk);
        ph = n_ph; age = n_age; own = n_own;
        t_we = n_we; t_addr = n_addr; t_wdata = n_wdata; t_wstrb = n_wstrb;
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            rand_fields();
            rst = 1'b1; m1_req = 1'($urandom); m2_req = 1'($urandom);
            s_ack = 1'($urandom); s_rsp_valid = 1'($urandom);
            sample();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL reset c%0d got=%h exp=%h", c, got, exp_v);
            end
            commit();
        end
        idle_inputs();
    endtask

    task automatic test_zero_wait_read();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            case (c)
                0: begin m2_req = 1'b1; m2_addr = 64'h80000010; end
                1: s_ack = 1'b1;
                2: begin s_rsp_valid = 1'b1; s_rdata = 64'hDEADBEEF; end
                default: ;
            endcase
            sample();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL zero_wait c%0d got=%h exp=%h", c, got, exp_v);
            end
            if (c == 2) begin
                vectors++;
                if ({m2_rsp_valid, m2_rdata} !== {1'b1, 64'hDEADBEEF}) begin
                    miscompares++;
                    $display("FAIL zero_wait_rdata got=%b/%h exp=1/00000000deadbeef", m2_rsp_valid, m2_rdata);
                end
            end
            if (c == 3) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL zero_wait_idle busy got=%b exp=0", busy);
                end
            end
            commit();
        end
    endtask

    task automatic test_aging();
        int gseq[$];
        int want[7] = '{2, 2, 2, 1, 2, 2, 1};
        idle_inputs(); rst = 1'b1;
        sample(); commit();
        for (int c = 0; c < 21; c++) begin
            idle_inputs(); rand_fields();
            m1_req = 1'b1; m2_req = 1'b1; s_ack = 1'b1; s_rsp_valid = (ph == 2);
            sample();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL aging c%0d got=%h exp=%h", c, got, exp_v);
            end
            if (m1_gnt) gseq.push_back(1);
            if (m2_gnt) gseq.push_back(2);
            commit();
        end
        idle_inputs();
        vectors++;
        if (gseq.size() != 7) begin
            miscompares++;
            $display("FAIL aging_count got=%0d exp=7", gseq.size());
        end
        for (int i = 0; i < 7 && i < gseq.size(); i++) begin
            vectors++;
            if (gseq[i] != want[i]) begin
                miscompares++;
                $display("FAIL aging_grant%0d got=m%0d exp=m%0d", i, gseq[i], want[i]);
            end
        end
    endtask

    task automatic test_stall_write();
        int n1 = 0, n2 = 0, nreq = 0;
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            if (c == 0) begin
                m1_req = 1'b1; m1_we = 1'b1; m1_wstrb = 8'h0F;
                m1_addr = {$urandom, $urandom}; m1_wdata = {$urandom, $urandom};
            end else begin
                rand_fields(); m1_req = 1'($urandom);
                s_rsp_valid = (c <= 5) ? 1'($urandom) : (c == 7);
                s_ack = (c == 6);
            end
            sample();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL stall_write c%0d got=%h exp=%h", c, got, exp_v);
            end
            n1 += int'(m1_rsp_valid); n2 += int'(m2_rsp_valid); nreq += int'(s_req);
            commit();
        end
        vectors++;
        if (n1 != 1 || n2 != 0 || nreq != 6) begin
            miscompares++;
            $display("FAIL stall_write_counts got=%0d/%0d/%0d exp=1/0/6", n1, n2, nreq);
        end
    endtask

    task automatic test_same_cycle();
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            if (c == 0) begin m2_req = 1'b1; m2_addr = {$urandom, $urandom}; end
            if (c == 1) begin s_ack = 1'b1; s_rsp_valid = 1'b1; s_rdata = {$urandom, $urandom}; end
            sample();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL same_cycle c%0d got=%h exp=%h", c, got, exp_v);
            end
            if (c == 1) begin
                vectors++;
                if ({m2_rsp_valid, m2_rdata} !== {1'b1, s_rdata}) begin
                    miscompares++;
                    $display("FAIL same_cycle_rsp got=%b/%h exp=1/%h", m2_rsp_valid, m2_rdata, s_rdata);
                end
            end
            if (c == 2) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL same_cycle_idle busy got=%b exp=0", busy);
                end
            end
            commit();
        end
    endtask

    task automatic test_reset_in_wait();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            case (c)
                0: begin m1_req = 1'b1; m1_addr = {$urandom, $urandom}; end
                1: s_ack = 1'b1;
                2: begin rst = 1'b1; m2_req = 1'b1; s_rsp_valid = 1'($urandom); end
                3: begin s_rsp_valid = 1'b1; s_rdata = {$urandom, $urandom}; end
                default: ;
            endcase
            sample();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL reset_wait c%0d got=%h exp=%h", c, got, exp_v);
            end
            if (c == 2 || c == 3) begin
                vectors++;
                if ({m1_gnt, m2_gnt, m1_rsp_valid, m2_rsp_valid, s_req, busy, owner} !== 7'b0) begin
                    miscompares++;
                    $display("FAIL reset_wait_quiet c%0d got=%b exp=0000000", c,
                             {m1_gnt, m2_gnt, m1_rsp_valid, m2_rsp_valid, s_req, busy, owner});
                end
            end
            commit();
        end
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            s_rsp_valid = 1'b1; s_rdata = {$urandom, $urandom};
            sample();
            vectors++;
            if ({m1_gnt, m2_gnt, m1_rsp_valid, m2_rsp_valid, s_req, busy,
                 m1_rdata, m2_rdata} !== 134'd0) begin
                miscompares++;
                $display("FAIL spurious c%0d got=%b%b%b%b%b%b %h %h exp=zeros", c, m1_gnt, m2_gnt,
                         m1_rsp_valid, m2_rsp_valid, s_req, busy, m1_rdata, m2_rdata);
            end
            commit();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rand_fields();
            rst = ($urandom_range(0, 63) == 0);
            m1_req = ($urandom_range(0, 2) != 0);
            m2_req = ($urandom_range(0, 2) != 0);
            s_ack = ($urandom_range(0, 2) != 0);
            s_rsp_valid = 1'($urandom);
            sample();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL random c%0d got=%h exp=%h", c, got, exp_v);
            end
            commit();
        end
        idle_inputs(); rst = 1'b1;
        sample(); commit();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_zero_wait_read();
        test_aging();
        test_stall_write();
        test_same_cycle();
        test_reset_in_wait();
        test_spurious();
        test_random();
        test_zero_wait_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AGE_MAX, default 8, meaning the number of consecutive cycles m1 may be denied before it gains priority (range 1..15).
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port mX_req  input  1  master X request (X=1 instruction fetch, X=2 data/load-store; REQ-004..REQ-011 exist for both).
REQ-005 SHALL have port mX_we  input  1  1=write, 0=read.
REQ-006 SHALL have port mX_addr  input  64  byte address.
REQ-007 SHALL have port mX_wdata  input  64  write data.
REQ-008 SHALL have port mX_wstrb  input  8  byte write strobes.
REQ-009 SHALL have port mX_gnt  output  1  one-cycle pulse: request accepted and captured.
REQ-010 SHALL have port mX_rsp_valid  output  1  one-cycle pulse: transaction complete.
REQ-011 SHALL have port mX_rdata  output  64  read data, valid with mX_rsp_valid.
REQ-012 SHALL have port s_req  output  1  request to shared SRAM port.
REQ-013 SHALL have ports s_we  output  1, s_addr  output  64, s_wdata  output  64 and s_wstrb  output  8, carrying the captured transaction fields.
REQ-014 SHALL have port s_ack  input  1  slave accepted the current s_req.
REQ-015 SHALL have port s_rsp_valid  input  1  slave completion, reads and writes.
REQ-016 SHALL have port s_rdata  input  64  slave read data.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port owner  output  1  0=m1 and 1=m2 own the current transaction; holds its last value while in IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE and WAIT_RSP; exactly one transaction is outstanding at a time.
REQ-020 In IDLE with any mX_req high, SHALL select a winner combinationally, pulse that master's mX_gnt in the same cycle, capture its we/addr/wdata/wstrb and owner, and enter ISSUE on the next edge.
REQ-021 Priority: m2 wins, unless age_cnt >= AGE_MAX with m1_req high, in which case m1 wins.
REQ-022 age_cnt: 4-bit; +1 per cycle in which m1_req is high and m1 is not granted (including cycles outside IDLE); saturates at AGE_MAX; cleared to 0 on m1_gnt.
REQ-023 In ISSUE, s_req SHALL be 1 and s_* SHALL hold the captured values, stable until s_ack.
REQ-024 ISSUE with s_ack=1 and s_rsp_valid=0: go to WAIT_RSP; s_req drops on the next cycle.
REQ-025 ISSUE with s_ack=1 and s_rsp_valid=1: complete immediately as in REQ-027 and go to IDLE.
REQ-026 ISSUE with s_ack=0: stay in ISSUE; s_rsp_valid is ignored.
REQ-027 In WAIT_RSP with s_rsp_valid=1, SHALL drive the owner's mX_rsp_valid=1 and mX_rdata=s_rdata combinationally in that cycle, then go to IDLE.
REQ-028 Non-owner mX_rsp_valid SHALL be 0; mX_rdata is don't-care when mX_rsp_valid=0.
REQ-029 s_rsp_valid in IDLE is spurious and SHALL be ignored: no output pulses, no state change.
REQ-030 SHALL re-arbitrate only in IDLE; the minimum period between grants is 3 cycles with a zero-wait slave.
REQ-031 mX_req dropped before mX_gnt SHALL be treated as withdrawn; after mX_gnt, the value of mX_req does not affect the captured transaction.
REQ-032 mX_gnt SHALL be 0 outside IDLE; at most one mX_gnt is high per cycle.

Reset
REQ-033 While rst=1 at a clock edge, SHALL set state to IDLE, age_cnt to 0, owner to 0 and all captured fields to 0.
REQ-034 While rst=1, all outputs SHALL be 0, including during the reset cycle itself.
REQ-035 Reset in ISSUE or WAIT_RSP SHALL abandon the transaction without a response pulse; a later s_rsp_valid is ignored per REQ-029.

Verification
REQ-036 Zero-wait read: m2_req=1, m2_addr=0x80000010 at cycle 0; s_ack=1 at cycle 1; s_rsp_valid=1, s_rdata=0xDEADBEEF at cycle 2 -> m2_gnt at cycle 0; s_req at cycle 1; m2_rsp_valid and m2_rdata=0xDEADBEEF at cycle 2; busy=0 at cycle 3.
REQ-037 Contention with aging, AGE_MAX=8: m1_req and m2_req held high continuously with a zero-wait slave -> m2 wins the first 3 grants; m1 wins the 4th grant (age reaches 8 after 8 denied cycles); age_cnt=0 afterward.
REQ-038 Write with slave stall: m1 write of wstrb=0x0F, s_ack held low for 5 cycles -> s_req and s_* stable for all 6 ISSUE cycles; m2_rsp_valid never asserts; m1_rsp_valid pulses once.
REQ-039 Same-cycle completion: s_ack=1 and s_rsp_valid=1 in the first ISSUE cycle -> owner response pulse in that cycle; IDLE next cycle; WAIT_RSP never entered.
REQ-040 Reset in WAIT_RSP: rst=1 for one cycle, then s_rsp_valid=1 -> no mX_rsp_valid pulse; all outputs 0 during reset; FSM in IDLE.
REQ-041 Spurious response: s_rsp_valid=1 in IDLE with no requests -> all outputs remain 0.
